// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate so (ptr+1) mod N sits at bit 0,
// take the lowest set bit, then map the rotated index back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req_i,
  input  logic [sel_width(N)-1:0]   ptr_i,
  output logic                      any_o,
  output logic [sel_width(N)-1:0]   winner_o
);

  localparam int SW = sel_width(N);
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);
  localparam logic [SW:0]   N_V      = (SW+1)'(N);

  logic [SW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  k;
  logic [SW:0]    sum;

  assign start = (ptr_i == PTR_LAST) ? '0 : ptr_i + 1'b1;
  assign dbl   = {req_i, req_i};
  assign rot   = dbl[start +: N];

  always_comb begin
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = SW'(i);
    end
  end

  assign any_o    = |req_i;
  assign sum      = {1'b0, k} + {1'b0, start};
  assign winner_o = (sum >= N_V) ? SW'(sum - N_V) : sum[SW-1:0];

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner selection for the shared 16-bit bus mux, with a
// one-cycle turnaround between owners and an optional hold limit.
//
// state   | meaning
// IDLE    | no owner; arbitrate on any request
// GRANT   | owner sel_q drives the bus; hold_q counts its cycles
// RELEASE | turnaround cycle with grant low; arbitrate past previous owner
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic                    done,
  output logic [N-1:0]            grant,
  output logic [sel_width(N)-1:0] sel,
  output logic                    busy,
  output logic                    timeout
);

  localparam int SW = sel_width(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = '1;
  localparam logic [SW-1:0] PTR_RST   = SW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          pick_any;
  logic [SW-1:0] pick_w;
  logic          owner_req;
  logic          hold_hit;

  rr_pick #(.N(N)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_w)
  );

  assign owner_req = req[sel_q];
  assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = N'(1) << pick_w;
          sel_d   = pick_w;
          ptr_d   = pick_w;
          hold_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (done || !owner_req || hold_hit) begin
          state_d   = RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          // a completed or abandoned transfer is never reported as a timeout
          timeout_d = hold_hit && !done && owner_req;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against an owner/pointer model of the arbiter.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   sel;
  logic         busy;
  logic         timeout;

  int passed = 0;
  int total  = 0;

  rr_bus_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the bus, who owned it last, how long it has held.
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_held  = 0;
  int   m_sel   = 0;
  bit   m_to    = 0;
  bit   model_on = 0;

  always @(posedge clk) begin
    bit lim;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_sel = 0; m_to = 0;
      model_on = 1;
    end else if (m_owner >= 0) begin
      m_held++;
      lim  = (MH != 0) && (m_held == MH);
      m_to = lim && !done && req[m_owner];
      if (done || !req[m_owner] || lim) m_owner = -1;
    end else begin
      m_to = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c] && m_owner < 0) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_held = 0; m_sel = m_owner;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("model_grant",   32'(grant),   32'(eg));
      chk("model_sel",     32'(sel),     32'(m_sel));
      chk("model_busy",    32'(busy),    32'(m_owner >= 0));
      chk("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic t);
    chk({nm, "_grant"},   32'(grant),   32'(g));
    chk({nm, "_sel"},     32'(sel),     32'(s));
    chk({nm, "_busy"},    32'(busy),    32'(b));
    chk({nm, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    // reset then single request
    rst = 1; req = 4'b0000; done = 0;
    tick(); tick();
    lit("reset", 4'b0000, 2'd0, 0, 0);
    rst = 0; req = 4'b0001;
    tick(); lit("first_grant", 4'b0001, 2'd0, 1, 0);
    done = 1;
    tick(); lit("done_release", 4'b0000, 2'd0, 0, 0);
    done = 0;
    tick(); lit("regrant", 4'b0001, 2'd0, 1, 0);

    // fairness rotation
    req = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (k % 4);
      done = 1;
      tick(); lit("rot_gap", 4'b0000, 2'd0 + 2'((k - 1) % 4), 0, 0);
      done = 0;
      tick(); lit("rot_grant", eg, 2'(k % 4), 1, 0);
    end

    // timeout on a single persistent requester
    req = 4'b0000;
    tick(); tick();
    req = 4'b0100;
    tick(); lit("to_grant", 4'b0100, 2'd2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); lit("to_hold", 4'b0100, 2'd2, 1, 0);
    end
    tick(); lit("to_pulse", 4'b0000, 2'd2, 0, 1);
    tick(); lit("to_regrant", 4'b0100, 2'd2, 1, 0);

    // done in the last allowed cycle beats the hold limit
    for (int k = 0; k < 3; k++) begin
      tick(); lit("prec_hold", 4'b0100, 2'd2, 1, 0);
    end
    done = 1;
    tick(); lit("prec_release", 4'b0000, 2'd2, 0, 0);
    done = 0;

    // owner drop and pointer wrap
    req = 4'b1000;
    tick(); lit("wrap_g3", 4'b1000, 2'd3, 1, 0);
    req = 4'b1001;
    tick(); lit("wrap_ignore", 4'b1000, 2'd3, 1, 0);
    req = 4'b0001;
    tick(); lit("wrap_drop", 4'b0000, 2'd3, 0, 0);
    tick(); lit("wrap_g0", 4'b0001, 2'd0, 1, 0);

    // reset mid-grant
    done = 1; req = 4'b0010;
    tick(); lit("mid_rel", 4'b0000, 2'd0, 0, 0);
    done = 0;
    tick(); lit("mid_g1", 4'b0010, 2'd1, 1, 0);
    rst = 1; req = 4'b1111;
    tick(); lit("mid_rst", 4'b0000, 2'd0, 0, 0);
    rst = 0;
    tick(); lit("mid_after", 4'b0001, 2'd0, 1, 0);

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; done = 0; req = 4'b0000;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
